// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported unified memory between the fetch stage
//   (instruction reads) and the memory stage (loads/stores). Accesses are
//   serialized; each one occupies the memory for WAIT_CYCLES cycles and
//   finishes with a one-cycle acknowledge to the requesting port. The data
//   port wins a simultaneous request. A port whose ack is high in the current
//   cycle is skipped for grant, so two ports streaming back-to-back alternate.
//
// Ports
//   clk, reset              system clock (rising edge), async active-low reset
//   if_req/if_addr          fetch read request (held until if_ack) and address
//   if_rdata/if_ack         registered fetch data, one-cycle completion pulse
//   stall_if                fetch stage must freeze
//   d_rd/d_wr               load/store request (held until d_ack)
//   d_addr/d_wdata          data address and store data
//   d_rdata/d_ack           registered load data, one-cycle completion pulse
//   stall_mem               memory stage must freeze
//   mem_addr/mem_wdata      memory address and write data (latched at grant)
//   mem_re/mem_we           memory read/write enables
//   mem_rdata               memory read data, valid in the last busy cycle
//
// States
//   IDLE   | no access in progress; grant evaluated every cycle
//   BUSY_I | fetch read in progress, counter counts down to 0
//   BUSY_D | load or store in progress, counter counts down to 0
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  output logic          stall_if,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          stall_mem,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  // A latency of zero cannot be honoured; it behaves as one wait state.
  localparam int WC = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CW = $clog2(WC + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [DW-1:0] wdata_q, wdata_nxt;
  logic          we_q, we_nxt;
  logic          if_ack_q, if_ack_nxt;
  logic          d_ack_q, d_ack_nxt;
  logic [DW-1:0] if_rdata_q, if_rdata_nxt;
  logic [DW-1:0] d_rdata_q, d_rdata_nxt;

  logic d_go;
  logic i_go;

  // A request whose ack is showing right now is the one just finished.
  assign d_go = (d_rd | d_wr) & ~d_ack_q;
  assign i_go = if_req & ~if_ack_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      we_q       <= we_nxt;
      if_ack_q   <= if_ack_nxt;
      d_ack_q    <= d_ack_nxt;
      if_rdata_q <= if_rdata_nxt;
      d_rdata_q  <= d_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    we_nxt       = we_q;
    if_ack_nxt   = 1'b0;
    d_ack_nxt    = 1'b0;
    if_rdata_nxt = if_rdata_q;
    d_rdata_nxt  = d_rdata_q;

    unique case (state)
      IDLE: begin
        if (d_go) begin
          state_nxt = BUSY_D;
          addr_nxt  = d_addr;
          wdata_nxt = d_wdata;
          we_nxt    = d_wr;     // rd and wr together count as a store
          cnt_nxt   = CNT_LOAD;
        end else if (i_go) begin
          state_nxt = BUSY_I;
          addr_nxt  = if_addr;
          we_nxt    = 1'b0;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY_I: begin
        if (cnt == '0) begin
          state_nxt    = IDLE;
          if_ack_nxt   = 1'b1;
          if_rdata_nxt = mem_rdata;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      BUSY_D: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          d_ack_nxt = 1'b1;
          if (!we_q) d_rdata_nxt = mem_rdata;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = (state == BUSY_I) | ((state == BUSY_D) & ~we_q);
  assign mem_we    = (state == BUSY_D) & we_q;

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = (d_rd | d_wr) & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        stall_if;
  logic        d_rd = 1'b0;
  logic        d_wr = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        stall_mem;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.WAIT_CYCLES(WC), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .stall_if(stall_if),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .stall_mem(stall_mem),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents: two fixed words, everything else a pattern of its address.
  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    if (a == 32'h40)  return 32'h2002_0005;
    if (a == 32'h100) return 32'h0000_0011;
    return a ^ 32'hA5A5_0000;
  endfunction

  always_comb mem_rdata = mem_re ? mem_lookup(mem_addr) : 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        fetch;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_re;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h40,  32'h0,         1'b1, 1'b0, 32'h2002_0005};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h0,         1'b1, 1'b0, 32'h0000_0011};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0011};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h300, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0011};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h304, 32'h0,         1'b1, 1'b0, 32'hA5A5_0304};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h44,  32'h0,         1'b1, 1'b0, 32'hA5A5_0044};

    // ---- reset held with random inputs ----
    for (int i = 0; i < 4; i++) begin
      if_req  = 1'($urandom);
      if_addr = $urandom;
      d_rd    = 1'($urandom);
      d_wr    = 1'($urandom);
      d_addr  = $urandom;
      d_wdata = $urandom;
      tick();
      chk("rst_if_ack", {31'b0, if_ack}, 32'h0);
      chk("rst_d_ack",  {31'b0, d_ack},  32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_rdata",  d_rdata,  32'h0);
      chk("rst_mem_re", {31'b0, mem_re}, 32'h0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
      chk("rst_mem_addr",  mem_addr,  32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_stall_if",  {31'b0, stall_if},  {31'b0, if_req});
      chk("rst_stall_mem", {31'b0, stall_mem}, {31'b0, d_rd | d_wr});
    end
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_mem_re", {31'b0, mem_re}, 32'h0);
      chk("idle_mem_we", {31'b0, mem_we}, 32'h0);
      chk("idle_acks",   {30'b0, if_ack, d_ack}, 32'h0);
    end

    // ---- table-driven single accesses ----
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].fetch) begin
        if_req = 1'b1; if_addr = vecs[v].addr;
      end else begin
        d_rd = vecs[v].rd; d_wr = vecs[v].wr;
        d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
      end
      #1;
      chk($sformatf("v%0d_stall_T", v),
          vecs[v].fetch ? {31'b0, stall_if} : {31'b0, stall_mem}, 32'h1);
      for (int c = 1; c <= WC; c++) begin
        tick();
        // scramble requester fields after grant; memory side must not move
        if_addr = ~vecs[v].addr; d_addr = ~vecs[v].addr; d_wdata = ~vecs[v].wdata;
        #1;
        chk($sformatf("v%0d_c%0d_re", v, c), {31'b0, mem_re}, {31'b0, vecs[v].exp_re});
        chk($sformatf("v%0d_c%0d_we", v, c), {31'b0, mem_we}, {31'b0, vecs[v].exp_we});
        chk($sformatf("v%0d_c%0d_addr", v, c), mem_addr, vecs[v].addr);
        if (!vecs[v].fetch)
          chk($sformatf("v%0d_c%0d_wdata", v, c), mem_wdata, vecs[v].wdata);
        chk($sformatf("v%0d_c%0d_noack", v, c), {30'b0, if_ack, d_ack}, 32'h0);
        chk($sformatf("v%0d_c%0d_stall", v, c),
            vecs[v].fetch ? {31'b0, stall_if} : {31'b0, stall_mem}, 32'h1);
      end
      tick();
      chk($sformatf("v%0d_ack", v), {30'b0, if_ack, d_ack},
          vecs[v].fetch ? 32'h2 : 32'h1);
      chk($sformatf("v%0d_rdata", v), vecs[v].fetch ? if_rdata : d_rdata,
          vecs[v].exp_rdata);
      chk($sformatf("v%0d_nostall", v), {30'b0, stall_if, stall_mem}, 32'h0);
      chk($sformatf("v%0d_idle_re", v), {30'b0, mem_re, mem_we}, 32'h0);
      if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
      tick();
      chk($sformatf("v%0d_ack_once", v), {30'b0, if_ack, d_ack}, 32'h0);
    end

    // ---- collision: data first, fetch granted in the data ack cycle ----
    if_req = 1'b1; if_addr = 32'h48;
    d_rd = 1'b1; d_addr = 32'h100;
    tick();
    chk("col_first_re",   {31'b0, mem_re}, 32'h1);
    chk("col_first_addr", mem_addr, 32'h100);
    tick();
    tick();
    chk("col_d_ack", {30'b0, if_ack, d_ack}, 32'h1);
    chk("col_d_rdata", d_rdata, 32'h11);
    d_rd = 1'b0;
    tick();
    chk("col_second_addr", mem_addr, 32'h48);
    chk("col_second_re", {31'b0, mem_re}, 32'h1);
    tick();
    chk("col_no_early_ack", {30'b0, if_ack, d_ack}, 32'h0);
    tick();
    chk("col_i_ack", {30'b0, if_ack, d_ack}, 32'h2);
    chk("col_if_rdata", if_rdata, 32'hA5A5_0048);
    if_req = 1'b0;
    tick();

    // ---- fairness: both held, acks alternate D,I,D,I,D ----
    if_req = 1'b1; if_addr = 32'h40;
    d_rd = 1'b1; d_addr = 32'h100;
    for (int c = 1; c <= 15; c++) begin
      tick();
      chk($sformatf("fair_c%0d_acks", c), {30'b0, if_ack, d_ack},
          (c % 6 == 3) ? 32'h1 : (c % 6 == 0) ? 32'h2 : 32'h0);
    end
    if_req = 1'b0; d_rd = 1'b0;
    tick();
    chk("fair_end_re", {31'b0, mem_re}, 32'h0);
    tick();

    // ---- reset in the first BUSY_D cycle ----
    d_rd = 1'b1; d_addr = 32'h104;
    tick();
    chk("mid_busy_re", {31'b0, mem_re}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_re_drop", {31'b0, mem_re}, 32'h0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    #1;
    d_rd = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    reset = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("post_rst_c%0d_dack", c), {31'b0, d_ack}, 32'h0);
      chk($sformatf("post_rst_c%0d_iack", c), {31'b0, if_ack}, (c == 3) ? 32'h1 : 32'h0);
    end
    chk("post_rst_if_rdata", if_rdata, 32'h2002_0005);
    chk("post_rst_d_rdata", d_rdata, 32'h0);
    if_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
